pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Next-generation program counter with a built-in hardware return-address stack, so the core gets call/return as well as relative and absolute jumps.
- Parametrised in address width and stack depth.
- Adds a pipeline stall input, a sticky halt, and sticky stack fault flags.
- Sits between the instruction decoder/branch logic and the instruction memory address port.

Parameters:
- D, 12, program address width in bits.
- DEPTH, 8, number of return-stack entries (>=2).
- RESET_ADDR, 0, value loaded into prog_ctr on reset (D bits).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  reset, synchronous, active-high.
- stall  input  1  hold all state this cycle (pipeline bubble).
- done  input  1  program finished; sets sticky halt.
- reljump_en  input  1  relative jump: prog_ctr + target.
- absjump_en  input  1  absolute jump: prog_ctr <= target.
- call_en  input  1  push return address, jump absolute to target.
- ret_en  input  1  pop return address into prog_ctr.
- target  input  D  jump offset (two's complement, relative) or absolute address.
- prog_ctr  output  D  current instruction address (registered).
- halted  output  1  sticky; high after done or a stack fault.
- stack_ovf  output  1  sticky; a call was attempted with the stack full.
- stack_unf  output  1  sticky; a return was attempted with the stack empty.
- depth  output  $clog2(DEPTH+1)  number of valid stack entries.

Behaviour:
- Reset values: prog_ctr=RESET_ADDR; depth=0; halted=0; stack_ovf=0; stack_unf=0. Stack contents are don't-care.
- Reset has top priority and is honoured mid-operation, including while halted or stalled.
- Per-cycle priority, evaluated only when reset=0:
  1. halted=1: all state held; every other input ignored.
  2. done=1: halted<=1; prog_ctr held. Done beats stall and any jump in the same cycle.
  3. stall=1: all state held.
  4. ret_en:
     - depth>0: prog_ctr<=stack[depth-1]; depth<=depth-1.
     - depth==0: stack_unf<=1; halted<=1; prog_ctr held.
  5. call_en:
     - depth<DEPTH: stack[depth]<=prog_ctr+1; prog_ctr<=target; depth<=depth+1.
     - depth==DEPTH: stack_ovf<=1; halted<=1; prog_ctr held; stack unchanged.
  6. reljump_en: prog_ctr<=prog_ctr+target.
  7. absjump_en: prog_ctr<=target.
  8. Otherwise: prog_ctr<=prog_ctr+1.
- Simultaneous control enables resolve strictly by the priority above. Lower-priority enables have no effect that cycle; for example, ret and call together perform only the ret.
- All address arithmetic is modulo 2^D:
  - Increment of all-ones wraps to 0.
  - The pushed return address wraps the same way.
  - A relative jump wraps in both directions.
- Latency: one cycle. The new prog_ctr is visible the cycle after the enabling edge.
- depth is registered and updates on the same edge as the push or pop.
- A push at depth==DEPTH-1 is legal and reaches full. A pop at depth==1 is legal and reaches empty.
- Faults and done are sticky until reset; there is no software clear.
- The stack is a register array indexed by depth; no memory macro is required.

Test Plan:
- Reset, then 3 free-running cycles (D=12, RESET_ADDR=0) -> prog_ctr 0,1,2,3; depth=0; all flags 0.
- At prog_ctr=5: call_en with target=0x100, then 2 increments, then ret_en -> prog_ctr 0x100,0x101,0x102,6; depth goes 1 then 0.
- DEPTH=8: 8 nested calls succeed (depth=8), then a 9th call -> stack_ovf=1, halted=1, prog_ctr frozen at the 8th call target; later jumps are ignored until reset.
- ret_en at depth=0 from prog_ctr=0x010 -> stack_unf=1, halted=1, prog_ctr stays 0x010. Reset -> flags clear, prog_ctr=RESET_ADDR.
- Wrap cases:
  - prog_ctr=0xFFF, no enables -> 0x000.
  - prog_ctr=0x002, reljump target=0xFFD (-3) -> 0xFFF.
  - call at 0xFFF -> pushed return address 0x000.
- Stall/done interaction:
  - stall with reljump_en high -> prog_ctr and depth unchanged.
  - done together with call_en -> halted=1, no push.
  - done deasserted afterwards -> PC stays frozen.
  - Reset while halted -> normal operation resumes.

Source files
------------

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with hardware return-address stack
// Priority: reset > halted > done > stall > ret > call > reljump > absjump > increment.
module pc_stack #(
  parameter int             D          = 12,
  parameter int             DEPTH      = 8,
  parameter logic [D-1:0]   RESET_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         done,
  input  logic                         reljump_en,
  input  logic                         absjump_en,
  input  logic                         call_en,
  input  logic                         ret_en,
  input  logic [D-1:0]                 target,
  output logic [D-1:0]                 prog_ctr,
  output logic                         halted,
  output logic                         stack_ovf,
  output logic                         stack_unf,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int              DW   = $clog2(DEPTH + 1);
  localparam int              AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0]   FULL = DW'(DEPTH);

  logic [D-1:0]  stack_mem [DEPTH];

  logic [D-1:0]  pc_inc;
  logic [D-1:0]  pc_nxt;
  logic [DW-1:0] depth_nxt;
  logic          halted_nxt;
  logic          ovf_nxt;
  logic          unf_nxt;
  logic          push_en;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] push_idx;

  // Arithmetic is naturally modulo 2^D because every result is D bits wide.
  assign pc_inc   = prog_ctr + D'(1);
  assign top_idx  = AW'(depth - DW'(1));
  assign push_idx = AW'(depth);

  always_comb begin
    pc_nxt     = prog_ctr;
    depth_nxt  = depth;
    halted_nxt = halted;
    ovf_nxt    = stack_ovf;
    unf_nxt    = stack_unf;
    push_en    = 1'b0;
    if (!halted) begin
      if (done) begin
        halted_nxt = 1'b1;
      end else if (!stall) begin
        if (ret_en) begin
          if (depth != '0) begin
            pc_nxt    = stack_mem[top_idx];
            depth_nxt = depth - DW'(1);
          end else begin
            unf_nxt    = 1'b1;
            halted_nxt = 1'b1;
          end
        end else if (call_en) begin
          if (depth != FULL) begin
            push_en   = 1'b1;
            pc_nxt    = target;
            depth_nxt = depth + DW'(1);
          end else begin
            ovf_nxt    = 1'b1;
            halted_nxt = 1'b1;
          end
        end else if (reljump_en) begin
          pc_nxt = prog_ctr + target;
        end else if (absjump_en) begin
          pc_nxt = target;
        end else begin
          pc_nxt = pc_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prog_ctr  <= RESET_ADDR;
      depth     <= '0;
      halted    <= 1'b0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      prog_ctr  <= pc_nxt;
      depth     <= depth_nxt;
      halted    <= halted_nxt;
      stack_ovf <= ovf_nxt;
      stack_unf <= unf_nxt;
    end
  end

  // Stack contents need no reset; only entries below depth are ever read.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - self-checking bench for pc_stack
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_pc_stack;

  localparam int D     = 12;
  localparam int DEPTH = 8;
  localparam int MASK  = (1 << D) - 1;
  localparam int RADDR = 0;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          done;
  logic          reljump_en;
  logic          absjump_en;
  logic          call_en;
  logic          ret_en;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          halted;
  logic          stack_ovf;
  logic          stack_unf;
  logic [$clog2(DEPTH+1)-1:0] depth;

  int n_checks = 0;
  int n_fail   = 0;

  int m_pc;
  int m_stack[$];
  bit m_halt, m_ovf, m_unf;

  pc_stack #(.D(D), .DEPTH(DEPTH), .RESET_ADDR(D'(RADDR))) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .done       (done),
    .reljump_en (reljump_en),
    .absjump_en (absjump_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .target     (target),
    .prog_ctr   (prog_ctr),
    .halted     (halted),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf),
    .depth      (depth)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_pc = RADDR;
      m_stack.delete();
      m_halt = 0; m_ovf = 0; m_unf = 0;
    end else if (m_halt) begin
    end else if (done) begin
      m_halt = 1;
    end else if (stall) begin
    end else if (ret_en) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin m_unf = 1; m_halt = 1; end
    end else if (call_en) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back((m_pc + 1) & MASK);
        m_pc = int'(target);
      end else begin
        m_ovf = 1; m_halt = 1;
      end
    end else if (reljump_en) begin
      m_pc = (m_pc + int'(target)) & MASK;
    end else if (absjump_en) begin
      m_pc = int'(target);
    end else begin
      m_pc = (m_pc + 1) & MASK;
    end
  endtask

  task automatic idle();
    reset = 0; stall = 0; done = 0; reljump_en = 0; absjump_en = 0;
    call_en = 0; ret_en = 0; target = '0;
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs compared 1ns later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("pc",     32'(prog_ctr),  32'(m_pc));
    check("depth",  32'(depth),     32'(m_stack.size()));
    check("halted", 32'(halted),    32'(m_halt));
    check("ovf",    32'(stack_ovf), 32'(m_ovf));
    check("unf",    32'(stack_unf), 32'(m_unf));
    idle();
  endtask

  task automatic do_reset();
    idle(); reset = 1; step();
  endtask

  task automatic do_abs(input int a);
    absjump_en = 1; target = D'(a); step();
  endtask

  initial begin
    m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
    idle();

    // reset and free running
    do_reset();
    check("rst_pc", 32'(prog_ctr), 32'(RADDR));
    check("rst_depth", 32'(depth), 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("free_pc", 32'(prog_ctr), 32'(i));
    end

    // call / return
    do_abs(5);
    call_en = 1; target = 12'h100; step();
    check("call_pc", 32'(prog_ctr), 32'h100);
    check("call_depth", 32'(depth), 1);
    step(); step();
    check("inc_pc", 32'(prog_ctr), 32'h102);
    ret_en = 1; step();
    check("ret_pc", 32'(prog_ctr), 32'h6);
    check("ret_depth", 32'(depth), 0);

    // overflow
    for (int i = 0; i < DEPTH; i++) begin
      call_en = 1; target = D'(12'h200 + i * 12'h10); step();
    end
    check("full_depth", 32'(depth), DEPTH);
    call_en = 1; target = 12'h777; step();
    check("ovf_flag", 32'(stack_ovf), 1);
    check("ovf_halt", 32'(halted), 1);
    check("ovf_pc", 32'(prog_ctr), 32'h270);
    do_abs(12'h123);
    check("ovf_frozen", 32'(prog_ctr), 32'h270);

    // underflow
    do_reset();
    do_abs(12'h010);
    ret_en = 1; step();
    check("unf_flag", 32'(stack_unf), 1);
    check("unf_pc", 32'(prog_ctr), 32'h010);
    do_reset();
    check("unf_clr", 32'(stack_unf), 0);
    check("unf_rst_pc", 32'(prog_ctr), 32'(RADDR));

    // wrap cases
    do_abs(12'hFFF);
    step();
    check("wrap_inc", 32'(prog_ctr), 0);
    do_abs(12'h002);
    reljump_en = 1; target = 12'hFFD; step();
    check("wrap_rel", 32'(prog_ctr), 32'hFFF);
    call_en = 1; target = 12'h050; step();
    ret_en = 1; step();
    check("wrap_push", 32'(prog_ctr), 0);

    // stall / done
    do_abs(12'h040);
    call_en = 1; target = 12'h300; step();
    stall = 1; reljump_en = 1; target = 12'h020; step();
    check("stall_pc", 32'(prog_ctr), 32'h300);
    check("stall_depth", 32'(depth), 1);
    done = 1; call_en = 1; target = 12'h500; step();
    check("done_halt", 32'(halted), 1);
    check("done_nopush", 32'(depth), 1);
    step(); step();
    check("done_frozen", 32'(prog_ctr), 32'h300);
    do_reset();
    step();
    check("resume_pc", 32'(prog_ctr), 32'(RADDR + 1));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 63) == 0);
      done       = ($urandom_range(0, 79) == 0);
      stall      = ($urandom_range(0, 7) == 0);
      ret_en     = ($urandom_range(0, 4) == 0);
      call_en    = ($urandom_range(0, 3) == 0);
      reljump_en = ($urandom_range(0, 3) == 0);
      absjump_en = ($urandom_range(0, 5) == 0);
      target     = D'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
